fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 130 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter that pops words from a FIFO and serialises them LSB first.
// Optional even-parity bit between data and stop is compiled in by FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_enable,
  input  logic                 empty,
  input  logic [DATA_SIZE-1:0] read_data_in,
  output logic                 read_from_fifo,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_SIZE-1:0] shift_reg;
  logic [DATA_SIZE-1:0] shift_next;
  logic                 baud_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // The pop is gated by reset so nothing leaves the FIFO while the block is held.
  assign read_from_fifo = reset && (state == IDLE) && tx_enable && !empty;
  assign busy           = (state != IDLE) || read_from_fifo;
  assign baud_done      = (baud_cnt == BAUD_LAST);
  assign shift_next     = shift_reg >> 1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b1;
          if (read_from_fifo) begin
            shift_reg <= read_data_in;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit <= ^read_data_in;
`endif
            tx        <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
              tx      <= parity_bit;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              // Bit 0 of the register is always the bit on the line.
              bit_cnt   <= bit_cnt + BIT_W'(1);
              shift_reg <= shift_next;
              tx        <= shift_next[0];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx (CLKS_PER_BIT=4, DATA_SIZE=8).
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FL = 45;
`else
  localparam int FL = 41;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_enable;
  logic       empty;
  logic [7:0] read_data_in;
  logic       read_from_fifo;
  logic       tx;
  logic       busy;

  logic [7:0] fifo_mem [0:63];
  logic [5:0] wr_ptr = '0;
  logic [5:0] rd_ptr = '0;
  logic [7:0] m_word;
  bit         frame_q[$];
  bit         chk_en = 1'b0;
  logic       e_rff;
  logic       e_tx;
  int         tests = 0;
  int         fails = 0;

  fifo_uart_tx #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .tx_enable(tx_enable),
    .empty(empty),
    .read_data_in(read_data_in),
    .read_from_fifo(read_from_fifo),
    .tx(tx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign empty        = (wr_ptr == rd_ptr);
  assign read_data_in = fifo_mem[rd_ptr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  // Reference: a frame is a list of line levels, one per clock, built when a word leaves the FIFO.
  always @(posedge clk) begin
    if (!reset) begin
      frame_q.delete();
    end else if (frame_q.size() != 0) begin
      void'(frame_q.pop_front());
    end else if (tx_enable && !empty) begin
      m_word = fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 6'd1;
      for (int b = 0; b < CPB; b++) frame_q.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int b = 0; b < CPB; b++) frame_q.push_back(m_word[i]);
`ifdef FIFO_UART_TX_PARITY_EN
      for (int b = 0; b < CPB; b++) frame_q.push_back(^m_word);
`endif
      for (int b = 0; b < CPB; b++) frame_q.push_back(1'b1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      e_rff = reset && (frame_q.size() == 0) && tx_enable && !empty;
      e_tx  = (frame_q.size() != 0) ? frame_q[0] : 1'b1;
      check("model_read_from_fifo", read_from_fifo, e_rff);
      check("model_busy", busy, (frame_q.size() != 0) || e_rff);
      check("model_tx", tx, e_tx);
    end
  end

  initial begin
    int a5_lvl[$];
    int busy_cnt;
    int ones;
    int pops;
    int txlow;

    reset = 1'b0;
    tx_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_rff", read_from_fifo, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // Single byte 8'hA5
    a5_lvl = '{0, 1, 0, 1, 0, 0, 1, 0, 1};
`ifdef FIFO_UART_TX_PARITY_EN
    a5_lvl.push_back(0);
`endif
    a5_lvl.push_back(1);
    push(8'hA5);
    tx_enable = 1'b1;
    @(negedge clk);
    check("a5_pop", read_from_fifo, 1);
    busy_cnt = busy ? 1 : 0;
    for (int n = 1; n <= FL + 3; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (read_from_fifo) check("a5_single_pop", read_from_fifo, 0);
      if (n < FL && ((n - 1) % CPB) == 1) check("a5_bit_level", tx, a5_lvl[(n - 1) / CPB]);
    end
    check("a5_busy_len", busy_cnt, FL);

    // Back-to-back 8'h00 then 8'hFF
    @(posedge clk); #1;
    push(8'h00);
    push(8'hFF);
    @(negedge clk);
    check("b2b_pop0", read_from_fifo, 1);
    ones = 0;
    pops = 0;
    for (int n = 1; n <= FL + 1; n++) begin
      @(negedge clk);
      if (tx) ones++;
      if (read_from_fifo) pops++;
      if (n == FL) begin
        check("b2b_pop1_spacing", read_from_fifo, 1);
        check("b2b_gap_tx", tx, 1);
      end
      if (n == FL + 1) check("b2b_next_start", tx, 0);
    end
    check("b2b_ones_run", ones, 5);
    check("b2b_pop_count", pops, 1);
    repeat (FL + 3) @(negedge clk);

    // Gating with tx_enable low
    @(posedge clk); #1;
    tx_enable = 1'b0;
    push(8'h5A);
    pops = 0; txlow = 0; busy_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (read_from_fifo) pops++;
      if (!tx) txlow++;
      if (busy) busy_cnt++;
    end
    check("gate_no_pop", pops, 0);
    check("gate_tx_high", txlow, 0);
    check("gate_not_busy", busy_cnt, 0);
    @(posedge clk); #1 tx_enable = 1'b1;
    @(negedge clk);
    check("gate_pop_on_enable", read_from_fifo, 1);
    repeat (FL + 3) @(negedge clk);

    // Reset in the middle of an 8'h3C frame
    @(posedge clk); #1;
    push(8'h3C);
    push(8'h81);
    @(negedge clk);
    check("rst_pop", read_from_fifo, 1);
    repeat (12) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_no_pop", read_from_fifo, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rst_repop", read_from_fifo, 1);
    repeat (2) @(negedge clk);
    check("rst_next_start", tx, 0);
    repeat (4) @(negedge clk);
    check("rst_next_word_bit0", tx, 1);
    repeat (FL) @(negedge clk);

    // Underflow: FIFO empty, tx_enable toggling
    pops = 0; txlow = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1 tx_enable = ~tx_enable;
      @(negedge clk);
      if (read_from_fifo) pops++;
      if (!tx) txlow++;
    end
    check("uf_no_pop", pops, 0);
    check("uf_tx_high", txlow, 0);

`ifdef FIFO_UART_TX_PARITY_EN
    @(posedge clk); #1;
    tx_enable = 1'b1;
    push(8'h07);
    @(negedge clk);
    check("par_pop", read_from_fifo, 1);
    busy_cnt = 1;
    for (int n = 1; n <= FL + 3; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (n == 38) check("par_bit", tx, 1);
    end
    check("par_busy_len", busy_cnt, 45);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
